uart_bram_cmd_engine: RTL and testbench

- Framed command engine between a UART byte interface (RX/TX) and a single-port byte-wide BRAM. It is the parametrised successor to the single-byte-command UART/BRAM controller.
- Supports addressed, length-bounded READ, WRITE and ERASE operations.
- Adds range checking, an inter-byte timeout, and an ACK/NAK response byte per frame.
- The BRAM is external to this block and connects through its port interface; it is not instantiated here.

---
 rtl/uart_bram_pkg.sv | 36 +++
 rtl/uart_bram_byte_timer.sv | 37 +++
 rtl/uart_bram_cmd_engine.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_uart_bram_cmd_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bram_pkg.sv
// Shared codes, status values and FSM states for the UART/BRAM command engine.
package uart_bram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h11;
  localparam logic [7:0] CMD_WRITE = 8'h12;
  localparam logic [7:0] CMD_ERASE = 8'h13;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_BAD_CMD = 2'b01;
  localparam logic [1:0] STAT_RANGE   = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  // ADDR_H, ADDR_L, LEN_H, LEN_L
  localparam int HDR_BYTES = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_CHECK,
    S_WR_DATA,
    S_ERASE,
    S_RD_FETCH,
    S_RD_LATCH,
    S_TX_SEND,
    S_TX_WAIT,
    S_RESP
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE) || (b == CMD_ERASE);
  endfunction

endpackage

// File: rtl/uart_bram_byte_timer.sv
// Inter-byte timeout: down-counter reloaded on every received byte and held
// at its reload value whenever the frame is not in a timed state.
module uart_bram_byte_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic reload,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload wins over countdown, saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (reload || !run) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A byte arriving in the expiry cycle suppresses the timeout.
  assign expire = run && !reload && (cnt_q == '0);

endmodule

// File: rtl/uart_bram_cmd_engine.sv
// Framed READ/WRITE/ERASE engine between a UART byte stream and an external
// single-port byte-wide BRAM, with range check, inter-byte timeout and an
// ACK/NAK response per frame.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a command byte
// S_HDR      | collecting ADDR_H, ADDR_L, LEN_H, LEN_L
// S_CHECK    | range/length check, dispatch on command
// S_WR_DATA  | one BRAM write per received data byte
// S_ERASE    | one ERASE_VALUE write per cycle
// S_RD_FETCH | BRAM read enable asserted
// S_RD_LATCH | read data captured into tx_data
// S_TX_SEND  | waiting for tx_busy low, then pulse tx_start
// S_TX_WAIT  | waiting for tx_busy to rise then fall
// S_RESP     | load ACK/NAK as the final response byte
module uart_bram_cmd_engine
  import uart_bram_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 12,
  parameter int          DEPTH          = 4096,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ERASE_VALUE    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [7:0]            bram_wdata,
  input  logic [7:0]            bram_rdata,
  output logic                  busy,
  output logic [1:0]            status
);

  localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
  localparam logic [1:0]  HDR_LAST = 2'(HDR_BYTES - 1);

  state_e                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [1:0]            hdr_cnt_q, hdr_cnt_d;
  logic [15:0]           addr_q, addr_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [1:0]            status_q, status_d;
  logic                  resp_nak_q, resp_nak_d;
  logic                  rd_mode_q, rd_mode_d;
  logic                  data_phase_q, data_phase_d;
  logic                  seen_busy_q, seen_busy_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  bram_en_q, bram_en_d;
  logic                  bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [7:0]            bram_wdata_q, bram_wdata_d;

  logic                  tmr_run;
  logic                  tmr_expire;
  logic [16:0]           end_sum;
  logic                  range_err;
  logic [ADDR_WIDTH-1:0] cur_addr_inc;

  assign tmr_run      = (state_q == S_HDR) || (state_q == S_WR_DATA);
  assign end_sum      = {1'b0, addr_q} + {1'b0, len_q};
  assign range_err    = (end_sum > DEPTH_W) || (({1'b0, addr_q} >> ADDR_WIDTH) != 17'd0);
  assign cur_addr_inc = cur_addr_q + 1'b1;

  uart_bram_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (tmr_run),
    .reload(rx_valid),
    .expire(tmr_expire)
  );

  // Frame sequencing; every output is computed here and registered below.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    hdr_cnt_d    = hdr_cnt_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    status_d     = status_q;
    resp_nak_d   = resp_nak_q;
    rd_mode_d    = rd_mode_q;
    data_phase_d = data_phase_q;
    seen_busy_d  = seen_busy_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    bram_en_d    = 1'b0;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (is_cmd(rx_data)) begin
            cmd_d     = rx_data;
            hdr_cnt_d = '0;
            state_d   = S_HDR;
          end else begin
            status_d   = STAT_BAD_CMD;
            resp_nak_d = 1'b1;
            state_d    = S_RESP;
          end
        end
      end

      S_HDR: begin
        if (rx_valid) begin
          case (hdr_cnt_q)
            2'd0:    addr_d[15:8] = rx_data;
            2'd1:    addr_d[7:0]  = rx_data;
            2'd2:    len_d[15:8]  = rx_data;
            default: len_d[7:0]   = rx_data;
          endcase
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == HDR_LAST) state_d = S_CHECK;
        end else if (tmr_expire) begin
          status_d   = STAT_TIMEOUT;
          resp_nak_d = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_CHECK: begin
        cur_addr_d = addr_q[ADDR_WIDTH-1:0];
        rem_d      = len_q;
        if (range_err) begin
          status_d   = STAT_RANGE;
          resp_nak_d = 1'b1;
          state_d    = S_RESP;
        end else if (len_q == 16'd0) begin
          status_d   = STAT_OK;
          resp_nak_d = 1'b0;
          state_d    = S_RESP;
        end else if (cmd_q == CMD_READ) begin
          // ACK goes out before the first data byte.
          tx_data_d    = RESP_ACK;
          rd_mode_d    = 1'b1;
          data_phase_d = 1'b0;
          state_d      = S_TX_SEND;
        end else if (cmd_q == CMD_WRITE) begin
          state_d = S_WR_DATA;
        end else begin
          state_d = S_ERASE;
        end
      end

      S_WR_DATA: begin
        if (rx_valid) begin
          bram_en_d    = 1'b1;
          bram_we_d    = 1'b1;
          bram_wdata_d = rx_data;
          bram_addr_d  = cur_addr_q;
          cur_addr_d   = cur_addr_inc;
          rem_d        = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            status_d   = STAT_OK;
            resp_nak_d = 1'b0;
            state_d    = S_RESP;
          end
        end else if (tmr_expire) begin
          status_d   = STAT_TIMEOUT;
          resp_nak_d = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_ERASE: begin
        bram_en_d    = 1'b1;
        bram_we_d    = 1'b1;
        bram_wdata_d = ERASE_VALUE;
        bram_addr_d  = cur_addr_q;
        cur_addr_d   = cur_addr_inc;
        rem_d        = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          status_d   = STAT_OK;
          resp_nak_d = 1'b0;
          state_d    = S_RESP;
        end
      end

      S_RD_FETCH: state_d = S_RD_LATCH;

      S_RD_LATCH: begin
        tx_data_d = bram_rdata;
        state_d   = S_TX_SEND;
      end

      S_TX_SEND: begin
        if (!tx_busy) begin
          tx_start_d  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        if (!seen_busy_q) begin
          if (tx_busy) seen_busy_d = 1'b1;
        end else if (!tx_busy) begin
          if (!rd_mode_q) begin
            state_d = S_IDLE;
          end else if (!data_phase_q) begin
            // ACK done: fetch the first byte. Enable is registered so it is
            // high for the whole of S_RD_FETCH.
            data_phase_d = 1'b1;
            bram_en_d    = 1'b1;
            bram_addr_d  = cur_addr_q;
            state_d      = S_RD_FETCH;
          end else if (rem_q == 16'd1) begin
            status_d  = STAT_OK;
            rd_mode_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            cur_addr_d  = cur_addr_inc;
            rem_d       = rem_q - 16'd1;
            bram_en_d   = 1'b1;
            bram_addr_d = cur_addr_inc;
            state_d     = S_RD_FETCH;
          end
        end
      end

      S_RESP: begin
        tx_data_d = resp_nak_q ? RESP_NAK : RESP_ACK;
        rd_mode_d = 1'b0;
        state_d   = S_TX_SEND;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      hdr_cnt_q    <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      status_q     <= '0;
      resp_nak_q   <= 1'b0;
      rd_mode_q    <= 1'b0;
      data_phase_q <= 1'b0;
      seen_busy_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      hdr_cnt_q    <= hdr_cnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cur_addr_q   <= cur_addr_d;
      rem_q        <= rem_d;
      status_q     <= status_d;
      resp_nak_q   <= resp_nak_d;
      rd_mode_q    <= rd_mode_d;
      data_phase_q <= data_phase_d;
      seen_busy_q  <= seen_busy_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign bram_en    = bram_en_q;
  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign status     = status_q;

endmodule

// File: tb/tb_uart_bram_cmd_engine.sv
// Bench for uart_bram_cmd_engine: BRAM and UART TX models, expected TX bytes
// queued by the stimulus and popped by a monitor on every tx_start.
module tb_uart_bram_cmd_engine;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int TO    = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_wdata;
  logic [7:0]    bram_rdata;
  logic          busy;
  logic [1:0]    status;

  int         n_cmp = 0;
  int         n_err = 0;
  int         tx_starts = 0;
  int         en_cnt = 0;
  int         busy_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] mem[DEPTH];

  always #5 clk = ~clk;

  uart_bram_cmd_engine #(
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO),
    .ERASE_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .busy(busy), .status(status)
  );

  // BRAM model: synchronous write, registered read.
  initial for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
  always @(posedge clk) if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
  always @(posedge clk or posedge rst)
    if (rst) bram_rdata <= 8'h00;
    else if (bram_en && !bram_we) bram_rdata <= mem[bram_addr];

  // UART TX model: busy for 4 cycles after a start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 4;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every transmitted byte is checked against the expected queue.
  always @(negedge clk) begin
    if (!rst && bram_en) en_cnt++;
    if (!rst && tx_start) begin
      tx_starts++;
      check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
      if (exp_q.size() == 0) check("tx_unexpected_byte", {24'd0, tx_data}, 32'h100);
      else                   check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al,
                          input logic [7:0] lh, input logic [7:0] ll);
    send_byte(c); send_byte(ah); send_byte(al); send_byte(lh); send_byte(ll);
  endtask

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(nm, {31'd0, busy}, 32'd0);
    check({nm, "_queue"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int s0;
    int n;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {26'd0, tx_start, bram_en, bram_we, busy, status}, 32'd0);
    check("reset_data", {4'd0, tx_data, bram_wdata, bram_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // WRITE AA BB CC to 0x010..0x012
    exp_q.push_back(8'h06);
    send_hdr(8'h12, 8'h00, 8'h10, 8'h00, 8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_idle("write_idle", 200);
    check("write_mem10", {24'd0, mem[12'h010]}, 32'hAA);
    check("write_mem11", {24'd0, mem[12'h011]}, 32'hBB);
    check("write_mem12", {24'd0, mem[12'h012]}, 32'hCC);
    check("write_status", {30'd0, status}, 32'd0);

    // READ them back, ACK first
    exp_q.push_back(8'h06); exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
    send_hdr(8'h11, 8'h00, 8'h10, 8'h00, 8'h03);
    wait_idle("read_idle", 300);
    check("read_status", {30'd0, status}, 32'd0);

    // ERASE two locations, exactly two write cycles
    exp_q.push_back(8'h06);
    e0 = en_cnt;
    send_hdr(8'h13, 8'h00, 8'h10, 8'h00, 8'h02);
    wait_idle("erase_idle", 200);
    check("erase_mem10", {24'd0, mem[12'h010]}, 32'h00);
    check("erase_mem11", {24'd0, mem[12'h011]}, 32'h00);
    check("erase_mem12", {24'd0, mem[12'h012]}, 32'hCC);
    check("erase_en_cycles", en_cnt - e0, 32'd2);

    // Range: 0x0FFF + 2 > DEPTH
    exp_q.push_back(8'h15);
    e0 = en_cnt;
    send_hdr(8'h11, 8'h0F, 8'hFF, 8'h00, 8'h02);
    wait_idle("range_idle", 200);
    check("range_status", {30'd0, status}, 32'd2);
    check("range_no_bram", en_cnt - e0, 32'd0);

    // Bad command
    exp_q.push_back(8'h15);
    send_byte(8'h55);
    wait_idle("badcmd_idle", 200);
    check("badcmd_status", {30'd0, status}, 32'd1);

    // Zero-length WRITE: ACK, no BRAM access
    exp_q.push_back(8'h06);
    e0 = en_cnt;
    send_hdr(8'h12, 8'h00, 8'h30, 8'h00, 8'h00);
    wait_idle("len0_idle", 200);
    check("len0_status", {30'd0, status}, 32'd0);
    check("len0_no_bram", en_cnt - e0, 32'd0);

    // Address bit above ADDR_WIDTH set
    exp_q.push_back(8'h15);
    send_hdr(8'h11, 8'h10, 8'h00, 8'h00, 8'h00);
    wait_idle("hiaddr_idle", 200);
    check("hiaddr_status", {30'd0, status}, 32'd2);

    // Timeout mid-header, then a normal frame
    exp_q.push_back(8'h15);
    s0 = tx_starts;
    send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
    repeat (40) @(negedge clk);
    check("timeout_not_early", {31'd0, busy}, 32'd1);
    check("timeout_no_tx_early", tx_starts - s0, 32'd0);
    wait_idle("timeout_idle", 200);
    check("timeout_status", {30'd0, status}, 32'd3);
    exp_q.push_back(8'h06);
    send_hdr(8'h12, 8'h00, 8'h20, 8'h00, 8'h01);
    send_byte(8'h5A);
    wait_idle("post_timeout_idle", 200);
    check("post_timeout_status", {30'd0, status}, 32'd0);
    check("post_timeout_mem20", {24'd0, mem[12'h020]}, 32'h5A);

    // Reset during a READ after the first data byte
    exp_q.push_back(8'h06); exp_q.push_back(8'hCC);
    s0 = tx_starts;
    send_hdr(8'h11, 8'h00, 8'h12, 8'h00, 8'h03);
    n = 0;
    while ((tx_starts - s0) < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_read_progress", tx_starts - s0, 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {26'd0, tx_start, bram_en, bram_we, busy, status}, 32'd0);
    check("rst_mid_data", {4'd0, tx_data, bram_wdata, bram_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_more_tx", tx_starts - s0, 32'd2);
    check("rst_busy_low", {31'd0, busy}, 32'd0);
    check("rst_queue", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
